sub39_share_arb: RTL and testbench

//  Shares one sub39 subtractor (out = A-B, WIDTH+1 bits, combinational) among NREQ

---
 rtl/sub39_share_arb.sv | 138 +++++++++++++
 tb/tb_sub39_share_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub39_share_arb.sv
// Shares one combinational sub39 subtractor among NREQ requesters with a round-robin
// arbiter; one operation in flight, result held until the consumer accepts it.

module sub39 #(
    parameter int WIDTH = 38
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] out
);
    assign out = a - b;
endmodule

module sub39_share_arb #(
    parameter int WIDTH = 38,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH:0]          resp_data,
    output logic                    resp_borrow,
    output logic [IDW-1:0]          resp_id,
    output logic                    busy,
    output logic [1:0]              state_dbg
);
    localparam int DW = WIDTH + 1;

    // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
    // ready never depends on anything but current inputs and registered state.
    typedef enum logic [1:0] {IDLE, EXEC, DONE, HOLD} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_q;
    logic [WIDTH:0]  a_q, b_q;
    logic [WIDTH:0]  diff;
    logic [IDW-1:0]  idx_hi, idx_lo, grant_idx, next_ptr;
    logic            found_hi, found_lo;
    logic [WIDTH:0]  a_sel, b_sel;
    logic            xfer;

    sub39 #(.WIDTH(WIDTH)) u_sub (
        .a   (a_q),
        .b   (b_q),
        .out (diff)
    );

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to lowest valid index.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                idx_lo   = IDW'(i);
                found_lo = 1'b1;
                if (IDW'(i) >= rr_ptr) begin
                    idx_hi   = IDW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (state == IDLE && found_lo && grant_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
                a_sel        = req_a[i*DW +: DW];
                b_sel        = req_b[i*DW +: DW];
            end
        end
        xfer = |req_ready;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (xfer) state_nx = EXEC;
            EXEC: state_nx = DONE;
            DONE: state_nx = HOLD;
            HOLD: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_borrow <= 1'b0;
            resp_id     <= '0;
        end else begin
            case (state)
                IDLE: if (xfer) begin
                    a_q    <= a_sel;
                    b_q    <= b_sel;
                    id_q   <= grant_idx;
                    rr_ptr <= next_ptr;
                end
                // Borrow comes from an explicit compare, not the subtractor's carry.
                DONE: begin
                    resp_data   <= diff;
                    resp_borrow <= (a_q < b_q);
                    resp_id     <= id_q;
                    resp_valid  <= 1'b1;
                end
                HOLD: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_sub39_share_arb.sv
// Directed plus randomized bench for sub39_share_arb against a round-robin/arithmetic
// reference model.

module tb_sub39_share_arb;
    localparam int WIDTH = 38;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DW    = WIDTH + 1;
    localparam int EW    = DW + IDW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a = '0;
    logic [NREQ*DW-1:0]   req_b = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b1;
    logic [DW-1:0]        resp_data;
    logic                 resp_borrow;
    logic [IDW-1:0]       resp_id;
    logic                 busy;
    logic [1:0]           state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    int gcyc = 0;
    logic [EW-1:0] exp_q[$];

    sub39_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_borrow (resp_borrow),
        .resp_id     (resp_id),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd_op();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return t[DW-1:0];
        endcase
    endfunction

    task automatic scramble_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = rnd_op();
            req_b[i*DW +: DW] = rnd_op();
        end
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [NREQ-1:0] v, input int hold, output int gnt);
        logic [EW-1:0] e;
        logic [DW-1:0] a, b;
        logic [63:0]   ed;
        int g;
        req_valid = v;
        #1;
        g = model_grant(v);
        gnt = g;
        check("req_ready_idle", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        a  = req_a[g*DW +: DW];
        b  = req_b[g*DW +: DW];
        ed = (64'(a) + (64'd1 << DW) - 64'(b)) % (64'd1 << DW);
        exp_q.push_back({(a < b), IDW'(g), ed[DW-1:0]});
        m_ptr = (g + 1) % NREQ;
        gcyc  = cyc;
        @(negedge clk);
        scramble_ops();
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_req_ready", 64'(req_ready), 64'd0);
        check("exec_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("done_resp_valid", 64'(resp_valid), 64'd0);
        check("done_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_data", 64'(resp_data), 64'(e[DW-1:0]));
        check("resp_id", 64'(resp_id), 64'(e[DW+IDW-1:DW]));
        check("resp_borrow", 64'(resp_borrow), 64'(e[EW-1]));
        if (hold > 0) begin
            resp_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 64'(resp_valid), 64'd1);
                check("hold_data", 64'(resp_data), 64'(e[DW-1:0]));
                check("hold_borrow", 64'(resp_borrow), 64'(e[EW-1]));
                check("hold_id", 64'(resp_id), 64'(e[DW+IDW-1:DW]));
                check("hold_req_ready", 64'(req_ready), 64'd0);
                check("hold_busy", 64'(busy), 64'd1);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check("release_valid", 64'(resp_valid), 64'd0);
        check("release_busy", 64'(busy), 64'd0);
        check("release_data_kept", 64'(resp_data), 64'(e[DW-1:0]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        check({tag, "_resp_borrow"}, 64'(resp_borrow), 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int g;
        int prev;
        logic [DW-1:0] all_ones;
        all_ones = '1;

        // Reset state (req_valid held low so req_ready must read 0 too)
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: 100 - 58 from requester 0
        set_op(0, DW'(100), DW'(58));
        do_op(4'b0001, 0, g);
        check("t1_grant", 64'(g), 64'd0);
        check("t1_data", 64'(resp_data), 64'd42);
        check("t1_borrow", 64'(resp_borrow), 64'd0);

        // Underflow and equal operands
        set_op(0, DW'(0), DW'(1));
        do_op(4'b0001, 0, g);
        check("t2_data", 64'(resp_data), 64'(all_ones));
        check("t2_borrow", 64'(resp_borrow), 64'd1);
        set_op(1, DW'('h55), DW'('h55));
        do_op(4'b0010, 0, g);
        check("t2_eq_data", 64'(resp_data), 64'd0);
        check("t2_eq_borrow", 64'(resp_borrow), 64'd0);

        // Wrap/skip: pointer to 3, only req1 valid, then all valid must grant 2
        scramble_ops();
        do_op(4'b0100, 0, g);
        check("t4_first", 64'(g), 64'd2);
        do_op(4'b0010, 0, g);
        check("t4_skip", 64'(g), 64'd1);
        do_op(4'b1111, 0, g);
        check("t4_next", 64'(g), 64'd2);

        // Backpressure for 10 cycles
        scramble_ops();
        do_op(4'b1111, 10, g);
        check("t5_grant", 64'(g), 64'd3);

        // Reset during EXEC drops the op
        scramble_ops();
        do_op(4'b0010, 0, g);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t6_exec_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_all_zero("t6");
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_resp", 64'(resp_valid), 64'd0);
        end

        // Fairness from pointer 0 with everyone valid
        prev = -1;
        for (int n = 0; n < 8; n++) begin
            int gc;
            scramble_ops();
            do_op(4'b1111, 0, g);
            check("t3_order", 64'(g), 64'(n % NREQ));
            gc = gcyc;
            if (prev >= 0) check("t3_spacing", 64'(gc - prev), 64'd4);
            prev = gc;
        end

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            scramble_ops();
            do_op(4'($urandom_range(0, 15)), $urandom_range(0, 3), g);
        end
        req_valid = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
